// File: rtl/psum_drain_ctrl.sv
// rtl/psum_drain_ctrl.sv - partial-sum drain controller at the output edge of the PE array
// Optional stall-cycle counter is enabled by defining PSUM_DRAIN_STALL_CNT_EN.
module psum_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic                           i_start,
    input  logic [ROWS*2*DATA_WIDTH-1:0]   i_ofmap,
    output logic                           o_psum_out_en,
    output logic                           o_reg_clear,
    output logic [ROWS*2*DATA_WIDTH-1:0]   o_data,
    output logic [$clog2(COLS):0]          o_col_idx,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_busy,
    output logic                           o_done
`ifdef PSUM_DRAIN_STALL_CNT_EN
    ,
    output logic [15:0]                    o_stall_cnt
`endif
);
    localparam int W  = ROWS * 2 * DATA_WIDTH;
    localparam int CW = $clog2(COLS) + 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cap_cnt_q;
    logic [W-1:0]  data_q;
    logic [CW-1:0] col_idx_q;
    logic          valid_q;

    logic can_cap;
    logic capture;
    logic accept;

    // The output register is a single slot: capture only when it is empty or draining now.
    assign can_cap = !valid_q || i_ready;
    assign capture = (state_q == S_DRAIN) && can_cap;
    assign accept  = valid_q && i_ready;

    // The chain shifts on the same edge that captures, so the next column arrives next cycle.
    assign o_psum_out_en = capture && (cap_cnt_q < LAST_COL);
    assign o_reg_clear   = (state_q == S_DONE);
    assign o_done        = (state_q == S_DONE);
    assign o_busy        = (state_q != S_IDLE);
    assign o_data        = data_q;
    assign o_col_idx     = col_idx_q;
    assign o_valid       = valid_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= S_IDLE;
            cap_cnt_q <= '0;
            data_q    <= '0;
            col_idx_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (accept) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q   <= S_DRAIN;
                        cap_cnt_q <= '0;
                    end
                end
                S_DRAIN: begin
                    if (can_cap) begin
                        data_q    <= i_ofmap;
                        col_idx_q <= cap_cnt_q;
                        valid_q   <= 1'b1;
                        cap_cnt_q <= cap_cnt_q + 1'b1;
                        if (cap_cnt_q == LAST_COL) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (accept) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PSUM_DRAIN_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE) begin
            if (i_start) begin
                stall_cnt_d = '0;
            end
        end else if (valid_q && !i_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// tb/tb_psum_drain_ctrl.sv - bench for psum_drain_ctrl with a PE row shift-register model
module tb_psum_drain_ctrl;
    localparam int DW   = 8;
    localparam int ROWS = 2;
    localparam int COLS = 4;
    localparam int W    = ROWS * 2 * DW;
    localparam int CW   = $clog2(COLS) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [W-1:0]  ofmap;
    logic [W-1:0]  data;
    logic [CW-1:0] col_idx;
    logic          psum_en, reg_clear, valid, busy, done;
`ifdef PSUM_DRAIN_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   stall_after_start;
`endif

    always #5 clk = ~clk;

    psum_drain_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .i_clk(clk), .i_nrst(rst_n), .i_start(start), .i_ofmap(ofmap),
        .o_psum_out_en(psum_en), .o_reg_clear(reg_clear), .o_data(data),
        .o_col_idx(col_idx), .o_valid(valid), .i_ready(ready),
        .o_busy(busy), .o_done(done)
`ifdef PSUM_DRAIN_STALL_CNT_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    // PE array model: each row is a shift register whose column 0 feeds i_ofmap
    logic [15:0] pe [ROWS][COLS];
    logic [15:0] ld [ROWS][COLS];
    logic [15:0] spec_rows [ROWS][COLS] = '{'{16'h0011, 16'h0022, 16'h0033, 16'h0044},
                                            '{16'hFFFE, 16'h0005, 16'h7FFF, 16'h8000}};
    logic        ld_req = 1'b0;

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (ld_req) begin
                for (int c = 0; c < COLS; c++) pe[r][c] <= ld[r][c];
            end else if (psum_en) begin
                for (int c = 0; c < COLS - 1; c++) pe[r][c] <= pe[r][c+1];
                pe[r][COLS-1] <= 16'hDEAD;
            end
        end
    end

    always_comb begin
        ofmap = '0;
        for (int r = 0; r < ROWS; r++) ofmap[r*16 +: 16] = pe[r][0];
    end

    // Monitor on the falling edge, away from the active edge
    int          cyc = 0, shifts = 0, dones = 0, viol = 0, done_cyc = 0;
    logic [63:0] obs [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) obs.push_back({29'b0, col_idx, data});
        if (psum_en) shifts++;
        if (psum_en && valid && !ready) viol++;
        if (psum_en && reg_clear) viol++;
        if (done) begin
            dones++;
            done_cyc = cyc;
            if (!reg_clear) viol++;
        end
    end

    int total = 0, bad = 0;
    int start_cyc, stable_bad, sh0, sh_stall;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic load_rows(input bit use_spec);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ld[r][c] = use_spec ? spec_rows[r][c] : 16'($urandom);
        ld_req = 1'b1;
        @(posedge clk); #1;
        ld_req = 1'b0;
    endtask

    function automatic logic [63:0] exp_word(input int c);
        logic [63:0] e;
        e = '0;
        e[34:32] = 3'(c);
        for (int r = 0; r < ROWS; r++) e[r*16 +: 16] = ld[r][c];
        return e;
    endfunction

    task automatic check_words(input string tag, input int base);
        chk({tag, "_count"}, 64'(obs.size() - base), COLS);
        for (int c = 0; c < COLS; c++)
            if (base + c < obs.size()) chk(tag, obs[base+c], exp_word(c));
    endtask

    // mode 0: ready high, 1: toggle pattern, 2: random, 3: 10-cycle stall, 4: extra starts
    task automatic run_drain(input int mode, output int dcyc);
        int k, d0, stall_left;
        logic [63:0] first;
        d0 = dones; k = 0; stall_left = 10; first = exp_word(0);
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef PSUM_DRAIN_STALL_CNT_EN
        stall_after_start = stall_cnt;
`endif
        while (dones == d0 && k < 80) begin
            case (mode)
                1: ready = pat[k % 6];
                2: ready = 1'($urandom_range(0, 1));
                3: begin
                    if (valid && stall_left > 0) begin
                        if (stall_left == 10) sh0 = shifts;
                        if ({29'b0, col_idx, data} !== first) stable_bad++;
                        ready = 1'b0;
                        stall_left--;
                    end else begin
                        if (stall_left == 0 && sh_stall < 0) sh_stall = shifts - sh0;
                        ready = 1'b1;
                    end
                end
                4: begin
                    ready = 1'b1;
                    start = (k == 1 || k == 4);
                end
                default: ready = 1'b1;
            endcase
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("done_seen", 64'(dones - d0), 1);
        dcyc = done_cyc - start_cyc;
    endtask

    initial begin
        int base, sh, d, d0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {valid, psum_en, reg_clear, busy, done, col_idx, data}, 64'd0);
`ifdef PSUM_DRAIN_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 16'd0);
`endif
        rst_n = 1'b1;

        load_rows(1'b1);
        base = obs.size(); sh = shifts;
        run_drain(0, d);
        chk("A_done_latency", d, 6);
        check_words("A_word", base);
        chk("A_shifts", shifts - sh, COLS - 1);
        chk("A_idle_after", busy, 1'b0);

        load_rows(1'b1);
        base = obs.size(); sh = shifts;
        run_drain(1, d);
        check_words("B_word", base);
        chk("B_shifts", shifts - sh, COLS - 1);

        load_rows(1'b1);
        base = obs.size(); sh = shifts; stable_bad = 0; sh_stall = -1;
        run_drain(3, d);
        chk("C_stable_data", stable_bad, 0);
        chk("C_no_shift_in_stall", 64'(sh_stall), 64'd0);
        check_words("C_word", base);
        chk("C_shifts", shifts - sh, COLS - 1);
`ifdef PSUM_DRAIN_STALL_CNT_EN
        chk("C_stall_cnt", stall_cnt, 16'd10);
`endif

        load_rows(1'b1);
        base = obs.size(); d0 = dones;
        run_drain(4, d);
`ifdef PSUM_DRAIN_STALL_CNT_EN
        chk("D_stall_cleared", stall_after_start, 16'd0);
`endif
        repeat (8) @(posedge clk);
        #1;
        chk("D_one_done", dones - d0, 1);
        check_words("D_word", base);
        chk("D_idle", busy, 1'b0);

        load_rows(1'b1);
        base = obs.size();
        ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 20 && obs.size() - base < 2; n++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("E_async_reset", {valid, psum_en, reg_clear, busy, done, col_idx, data}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_rows(1'b0);
        base = obs.size(); sh = shifts;
        run_drain(0, d);
        check_words("E_fresh_word", base);
        chk("E_shifts", shifts - sh, COLS - 1);

        for (int i = 0; i < 3; i++) begin
            load_rows(1'b0);
            base = obs.size(); sh = shifts;
            run_drain(2, d);
            check_words("R_word", base);
            chk("R_shifts", shifts - sh, COLS - 1);
        end

        chk("invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
